// File: rtl/pc_gen.sv
// Purpose: fetch PC generator with prioritised redirects, decode prediction and a return-address stack.
// Latency: next PC is registered; a selection made in cycle N is presented on fetch_pc in cycle N+1.
// Backpressure: fetch_ready low holds the PC; only redir_valid redirects and ras_flush act while stalled.
module pc_gen #(
    parameter int                 XLEN         = 32,
    parameter logic [XLEN-1:0]    RESET_VECTOR = '0,
    parameter int                 FETCH_BYTES  = 4,
    parameter int                 NUM_REDIR    = 2,
    parameter int                 RAS_DEPTH    = 4,
    parameter int                 EPOCH_W      = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      fetch_valid,
    input  logic                      fetch_ready,
    output logic [XLEN-1:0]           fetch_pc,
    output logic [EPOCH_W-1:0]        fetch_epoch,
    output logic                      fetch_misaligned,
    input  logic [NUM_REDIR-1:0]      redir_valid,
    input  logic [NUM_REDIR*XLEN-1:0] redir_pc,
    input  logic                      pred_valid,
    input  logic [XLEN-1:0]           pred_pc,
    input  logic                      ras_push,
    input  logic [XLEN-1:0]           ras_push_addr,
    input  logic                      ras_pop,
    input  logic                      ras_flush,
    output logic                      ras_empty
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    // Return-address storage carries no reset; count and pointer define which entries are live.
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr;      // next write slot; top lives at ras_ptr-1
    logic [CW-1:0]   ras_cnt;

    logic            fetch_fire;
    logic            redir_any;
    logic [XLEN-1:0] redir_tgt;
    logic            push_vld;
    logic            pop_vld;
    logic [PW-1:0]   top_idx;
    logic [XLEN-1:0] ras_top;
    logic [PW-1:0]   wr_idx;
    logic [XLEN-1:0] pc_nxt;
    logic [PW-1:0]   ras_ptr_nxt;
    logic [CW-1:0]   ras_cnt_nxt;

    assign fetch_fire       = fetch_valid & fetch_ready;
    assign redir_any        = |redir_valid;
    assign ras_empty        = (ras_cnt == '0);
    assign fetch_misaligned = |fetch_pc[1:0];
    assign top_idx          = ras_ptr - PW'(1);
    assign ras_top          = ras_mem[top_idx];
    // Flush wins over push/pop; a pop on an empty stack is a no-op.
    assign push_vld         = fetch_fire & ras_push & ~ras_flush;
    assign pop_vld          = fetch_fire & ras_pop & ~ras_flush & ~ras_empty;
    // Push+pop together replaces the top in place instead of moving the pointer.
    assign wr_idx           = pop_vld ? top_idx : ras_ptr;

    // Pick the lowest-index asserted redirect target by scanning from the top index down.
    always_comb begin
        redir_tgt = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) redir_tgt = redir_pc[i*XLEN +: XLEN];
        end
    end

    // Next-PC selection: redirect, then RAS pop, then prediction, then sequential; hold when stalled.
    always_comb begin
        pc_nxt = fetch_pc;
        if (redir_any) begin
            pc_nxt = redir_tgt;
        end else if (fetch_fire) begin
            if (pop_vld)         pc_nxt = ras_top;
            else if (pred_valid) pc_nxt = pred_pc;
            else                 pc_nxt = fetch_pc + XLEN'(FETCH_BYTES);
        end
    end

    // RAS pointer/count update; a push when full keeps the count and overwrites the oldest slot.
    always_comb begin
        ras_ptr_nxt = ras_ptr;
        ras_cnt_nxt = ras_cnt;
        if (ras_flush) begin
            ras_cnt_nxt = '0;
        end else if (push_vld && !pop_vld) begin
            ras_ptr_nxt = ras_ptr + PW'(1);
            if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt_nxt = ras_cnt + CW'(1);
        end else if (pop_vld && !push_vld) begin
            ras_ptr_nxt = top_idx;
            ras_cnt_nxt = ras_cnt - CW'(1);
        end
    end

    // Architectural state: PC, valid, epoch and RAS bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_VECTOR;
            fetch_valid <= 1'b0;
            fetch_epoch <= '0;
            ras_ptr     <= '0;
            ras_cnt     <= '0;
        end else begin
            fetch_pc    <= pc_nxt;
            fetch_valid <= 1'b1;
            if (redir_any) fetch_epoch <= fetch_epoch + EPOCH_W'(1);
            ras_ptr     <= ras_ptr_nxt;
            ras_cnt     <= ras_cnt_nxt;
        end
    end

    // RAS entry write.
    always_ff @(posedge clk) begin
        if (push_vld) ras_mem[wr_idx] <= ras_push_addr;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Parameters
REQ-001 XLEN, default 32: PC width in bits.
REQ-002 RESET_VECTOR, default 32'h00000000: PC loaded at reset (XLEN bits).
REQ-003 FETCH_BYTES, default 4: sequential PC increment, 4 or 8.
REQ-004 NUM_REDIR, default 2: redirect sources; index 0 has highest priority.
REQ-005 RAS_DEPTH, default 4: return-address-stack entries, power of 2, at least 2.
REQ-006 EPOCH_W, default 3: width of the redirect epoch counter.

Interface
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 fetch_valid  out  1  fetch_pc is presented to fetch.
REQ-010 fetch_ready  in  1  fetch accepts fetch_pc this cycle.
REQ-011 fetch_pc  out  XLEN  current fetch address.
REQ-012 fetch_epoch  out  EPOCH_W  epoch tag of fetch_pc.
REQ-013 fetch_misaligned  out  1  fetch_pc[1:0] != 0.
REQ-014 redir_valid  in  NUM_REDIR  per-source redirect request.
REQ-015 redir_pc  in  NUM_REDIR*XLEN  redirect targets; source i occupies bits [i*XLEN +: XLEN].
REQ-016 pred_valid  in  1  decode-stage predicted-taken target request.
REQ-017 pred_pc  in  XLEN  predicted target.
REQ-018 ras_push  in  1  push ras_push_addr onto the RAS.
REQ-019 ras_push_addr  in  XLEN  return address to push.
REQ-020 ras_pop  in  1  pop the RAS and redirect to its top.
REQ-021 ras_flush  in  1  empty the RAS.
REQ-022 ras_empty  out  1  RAS holds 0 entries.

Function
REQ-023 Next-PC priority, highest first:
  - lowest-index asserted redir_valid[i] selects redir_pc[i];
  - else ras_pop with RAS non-empty selects the RAS top;
  - else pred_valid selects pred_pc;
  - else fetch_valid && fetch_ready selects fetch_pc + FETCH_BYTES;
  - else fetch_pc holds.
REQ-024 Sequential add is modulo 2^XLEN; 2^XLEN - FETCH_BYTES wraps to 0.
REQ-025 redir_valid redirects apply in the same edge regardless of fetch_ready (a stalled fetch does not block them).
REQ-026 pred_valid and ras_pop redirects apply only when fetch_valid && fetch_ready; otherwise they are ignored and the PC holds.
REQ-027 fetch_epoch increments by 1, mod 2^EPOCH_W, on every edge that applies a redir_valid redirect; pred and RAS redirects do not change it.
REQ-028 fetch_misaligned is combinational from fetch_pc; misaligned targets load unchanged and no masking is applied.
REQ-029 fetch_valid is 0 during reset, becomes 1 on the first edge after rst_n deasserts, then stays 1.
REQ-030 A redirect in the same cycle as an accepted fetch completes that handshake; the redirect target is presented next cycle.
REQ-031 RAS is circular with a pointer and a count 0..RAS_DEPTH; RAS top is the most recently pushed live entry.
REQ-032 RAS push when full overwrites the oldest entry; count stays at RAS_DEPTH.
REQ-033 RAS pop when empty: no state change, no redirect, and pred/sequential selection proceeds.
REQ-034 RAS push and pop in the same cycle: next PC is the old top, the top entry is replaced with ras_push_addr, and count is unchanged (also applies when full).
REQ-035 ras_flush sets count to 0 and overrides a same-cycle push or pop; a pop in that cycle does not redirect.
REQ-036 RAS push/pop take effect only when qualified by fetch_valid && fetch_ready; ras_flush is unconditional.
REQ-037 ras_empty is 1 when count equals 0.

Reset
REQ-038 rst_n low asynchronously sets fetch_pc=RESET_VECTOR, fetch_valid=0, fetch_epoch=0, RAS count=0 and pointer=0 (ras_empty=1).
REQ-039 Reset asserted mid-operation discards pending redirects and RAS contents immediately; RAS entry storage needs no reset.

Verification
REQ-040 Release reset with fetch_ready=1 -> cycle 1 fetch_pc=0x0, valid=1; then 0x4, 0x8; epoch=0.
REQ-041 fetch_ready=0 and redir_valid=2'b11 with targets 0x100 (i=0) and 0x200 (i=1) -> next fetch_pc=0x100, epoch=1.
REQ-042 Push 0x10, 0x20, 0x30, 0x40, 0x50 (depth 4), then five pops -> redirects to 0x50, 0x40, 0x30, 0x20; fifth pop has no redirect and falls to sequential; ras_empty=1.
REQ-043 fetch_pc=0xFFFFFFFC, FETCH_BYTES=4, accept -> fetch_pc=0x0.
REQ-044 Same cycle: pred_valid with 0x80, ras_pop with top 0x300, redir_valid[1] with 0x400 -> 0x400; RAS count decrements (pop honoured, its redirect overridden); epoch +1.
REQ-045 redir_pc=0x102 -> fetch_misaligned=1; rst_n pulsed low mid-run -> fetch_pc=RESET_VECTOR, valid=0, ras_empty=1 without waiting for a clock edge.
